// File: rtl/var_delay_line_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | var_delay_pkg : shared types and delay clamping for var_delay_line        |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package var_delay_pkg;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  function automatic int unsigned clamp_delay(input int unsigned cfg,
                                              input int unsigned max_delay);
    if (cfg == 0) return 1;
    if (cfg > max_delay) return max_delay;
    return cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/var_delay_line_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | var_delay_line_if : data/config/status bundle of the variable delay line   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface var_delay_line_if #(
  parameter int DATA_SIZE = 256,
  parameter int MAX_DELAY = 16
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic                 en;
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in;
  logic                 in_ready;
  logic [DW-1:0]        delay_cfg;
  logic                 cfg_load;
  logic                 out_valid;
  logic [DATA_SIZE-1:0] out;
  logic                 busy;

  modport master (
    output en, in_valid, in, delay_cfg, cfg_load,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  en, in_valid, in, delay_cfg, cfg_load,
    output in_ready, out_valid, out, busy
  );
endinterface
`default_nettype wire

// File: rtl/var_delay_line_ring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delay_ring : MAX_DELAY-entry ring of {valid,data}, tap read at wptr-D      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module delay_ring #(
  parameter int DATA_SIZE = 256,
  parameter int MAX_DELAY = 16,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  wire logic                 clk,
  input  wire logic                 rstn,
  input  wire logic                 adv,
  input  wire logic                 wr_valid,
  input  wire logic [DATA_SIZE-1:0] wr_data,
  input  wire logic [DW-1:0]        d,
  output logic                      rd_valid,
  output logic [DATA_SIZE-1:0]      rd_data
);
  localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [DATA_SIZE-1:0] r_mem [MAX_DELAY];
  logic [MAX_DELAY-1:0] r_vld;
  logic [PW-1:0]        r_wptr;
  logic [31:0]          w_sum;
  logic [PW-1:0]        w_tap;

  assign w_sum = 32'(r_wptr) + 32'(MAX_DELAY) - 32'(d);
  assign w_tap = (w_sum >= 32'(MAX_DELAY)) ? PW'(w_sum - 32'(MAX_DELAY)) : PW'(w_sum);

  assign rd_valid = r_vld[w_tap];
  assign rd_data  = r_mem[w_tap];

  // The tapped slot is consumed as it is shown, so a later change of D can
  // never re-expose a word that has already been emitted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vld  <= '0;
      r_wptr <= '0;
    end else if (adv) begin
      r_vld[w_tap]  <= 1'b0;
      r_vld[r_wptr] <= wr_valid;
      r_wptr        <= (r_wptr == PW'(MAX_DELAY - 1)) ? '0 : r_wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) r_mem[r_wptr] <= wr_data;
  end
endmodule
`default_nettype wire

// File: rtl/var_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | var_delay_line : programmable-latency valid-tagged delay with drain/switch |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module var_delay_line
  import var_delay_pkg::*;
#(
  parameter int DATA_SIZE     = 256,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 2
) (
  input wire logic          clk,
  input wire logic          rstn,
  var_delay_line_if.slave   bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  typedef struct packed {
    state_t        st;
    logic [DW-1:0] d;
    logic [DW-1:0] pend;
    logic [DW-1:0] occ;
  } ctl_t;

  ctl_t                 r_cur;
  ctl_t                 w_nxt;
  logic                 w_accept;
  logic                 w_emit;
  logic                 w_rd_valid;
  logic [DATA_SIZE-1:0] w_rd_data;
  logic [DW-1:0]        w_clamped;

  assign w_accept  = bus.en & bus.in_valid & (r_cur.st == RUN);
  assign w_emit    = bus.en & w_rd_valid;
  assign w_clamped = DW'(clamp_delay(32'(bus.delay_cfg), 32'(MAX_DELAY)));

  delay_ring #(
    .DATA_SIZE (DATA_SIZE),
    .MAX_DELAY (MAX_DELAY),
    .DW        (DW)
  ) u_ring (
    .clk      (clk),
    .rstn     (rstn),
    .adv      (bus.en),
    .wr_valid (w_accept),
    .wr_data  (w_accept ? bus.in : '0),
    .d        (r_cur.d),
    .rd_valid (w_rd_valid),
    .rd_data  (w_rd_data)
  );

  // cfg_load is honoured even when stalled; only the drain waits for en.
  always_comb begin
    w_nxt = r_cur;
    if (bus.en) w_nxt.occ = r_cur.occ + DW'(w_accept) - DW'(w_emit);
    if (bus.cfg_load) w_nxt.pend = w_clamped;
    if (r_cur.st == RUN) begin
      if (bus.cfg_load) w_nxt.st = DRAIN;
    end else begin
      if (bus.en && (w_nxt.occ == '0)) begin
        w_nxt.st = RUN;
        w_nxt.d  = w_nxt.pend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cur.st   <= RUN;
      r_cur.d    <= DW'(DEFAULT_DELAY);
      r_cur.pend <= DW'(DEFAULT_DELAY);
      r_cur.occ  <= '0;
    end else begin
      r_cur <= w_nxt;
    end
  end

  assign bus.in_ready  = (r_cur.st == RUN);
  assign bus.busy      = (r_cur.st == DRAIN);
  assign bus.out_valid = w_rd_valid;
  assign bus.out       = w_rd_valid ? w_rd_data : '0;
endmodule
`default_nettype wire

// File: tb/tb_var_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_var_delay_line : directed self-checking bench for var_delay_line        |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_var_delay_line;
  localparam int DS = 256;
  localparam int MD = 16;
  localparam int DW = 5;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  var_delay_line_if #(.DATA_SIZE(DS), .MAX_DELAY(MD)) vif ();

  var_delay_line #(
    .DATA_SIZE     (DS),
    .MAX_DELAY     (MD),
    .DEFAULT_DELAY (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (vif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ev, input logic [DS-1:0] ed,
                     input logic er, input logic eb);
    logic [DS+2:0] obs;
    logic [DS+2:0] exp;
    obs = {vif.out_valid, vif.in_ready, vif.busy, vif.out};
    exp = {ev, er, eb, ed};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed v/r/b=%b%b%b out=%h expected v/r/b=%b%b%b out=%h",
             tag, obs[DS+2], obs[DS+1], obs[DS], obs[DS-1:0], ev, er, eb, ed);
    end
  endtask

  // Drive one cycle of inputs, check the visible outputs, then advance.
  task automatic cyc(input string tag, input logic e, input logic v,
                     input logic [DS-1:0] d, input logic cl, input logic [DW-1:0] cfg,
                     input logic ev, input logic [DS-1:0] ed, input logic er, input logic eb);
    vif.en = e; vif.in_valid = v; vif.in = d; vif.cfg_load = cl; vif.delay_cfg = cfg;
    chk(tag, ev, ed, er, eb);
    tick();
  endtask

  initial begin
    clk = 1'b0; rstn = 1'b0; checks = 0; failures = 0;
    vif.en = 1'b0; vif.in_valid = 1'b0; vif.in = '0; vif.cfg_load = 1'b0; vif.delay_cfg = '0;
    tick();
    tick();
    chk("reset", 1'b0, '0, 1'b1, 1'b0);
    rstn = 1'b1;

    // Basic stream at D=2: out_valid 0,0,1,1,1,0
    cyc("s1_c0", 1, 1, 'h1, 0, 0,  0, 'h0, 1, 0);
    cyc("s1_c1", 1, 1, 'h2, 0, 0,  0, 'h0, 1, 0);
    cyc("s1_c2", 1, 1, 'h3, 0, 0,  1, 'h1, 1, 0);
    cyc("s1_c3", 1, 0, 'h0, 0, 0,  1, 'h2, 1, 0);
    cyc("s1_c4", 1, 0, 'h0, 0, 0,  1, 'h3, 1, 0);
    cyc("s1_c5", 1, 0, 'h0, 0, 0,  0, 'h0, 1, 0);

    // Stall mid-stream; a word offered while en=0 must not be taken
    cyc("s2_c0", 1, 1, 'h11, 0, 0, 0, 'h0,  1, 0);
    cyc("s2_c1", 1, 1, 'h12, 0, 0, 0, 'h0,  1, 0);
    cyc("s2_c2", 0, 1, 'h99, 0, 0, 1, 'h11, 1, 0);
    cyc("s2_c3", 0, 1, 'h99, 0, 0, 1, 'h11, 1, 0);
    cyc("s2_c4", 0, 1, 'h99, 0, 0, 1, 'h11, 1, 0);
    cyc("s2_c5", 1, 1, 'h13, 0, 0, 1, 'h11, 1, 0);
    cyc("s2_c6", 1, 0, 'h0,  0, 0, 1, 'h12, 1, 0);
    cyc("s2_c7", 1, 0, 'h0,  0, 0, 1, 'h13, 1, 0);
    cyc("s2_c8", 1, 0, 'h0,  0, 0, 0, 'h0,  1, 0);

    // Switch 2 -> 5 with two words in flight; offers during DRAIN are refused
    cyc("s3_c0", 1, 1, 'h5,  0, 0, 0, 'h0, 1, 0);
    cyc("s3_c1", 1, 1, 'h6,  1, 5, 0, 'h0, 1, 0);
    cyc("s3_c2", 1, 1, 'h77, 0, 0, 1, 'h5, 0, 1);
    cyc("s3_c3", 1, 1, 'h77, 0, 0, 1, 'h6, 0, 1);
    cyc("s3_c4", 1, 1, 'hA,  0, 0, 0, 'h0, 1, 0);
    for (int i = 5; i < 9; i++)
      cyc($sformatf("s3_c%0d", i), 1, 0, 'h0, 0, 0, 0, 'h0, 1, 0);
    cyc("s3_c9",  1, 0, 'h0, 0, 0, 1, 'hA, 1, 0);
    cyc("s3_c10", 1, 0, 'h0, 0, 0, 0, 'h0, 1, 0);

    // Clamp 0 then overwrite during a stalled DRAIN with an over-range value
    // (31 is the largest value a 5-bit delay_cfg can carry)
    cyc("s4_c0", 1, 0, 'h0,  1, 0,  0, 'h0, 1, 0);
    cyc("s4_c1", 0, 0, 'h0,  1, 31, 0, 'h0, 0, 1);
    cyc("s4_c2", 1, 0, 'h0,  0, 0,  0, 'h0, 0, 1);
    cyc("s4_c3", 1, 1, 'h42, 0, 0,  0, 'h0, 1, 0);
    for (int i = 4; i < 19; i++)
      cyc($sformatf("s4_c%0d", i), 1, 0, 'h0, 0, 0, 0, 'h0, 1, 0);
    cyc("s4_c19", 1, 0, 'h0, 0, 0, 1, 'h42, 1, 0);
    cyc("s4_c20", 1, 0, 'h0, 0, 0, 0, 'h0,  1, 0);

    // Empty drain to D=1: busy for exactly one cycle
    cyc("s5_c0", 1, 0, 'h0,  1, 1, 0, 'h0,  1, 0);
    cyc("s5_c1", 1, 0, 'h0,  0, 0, 0, 'h0,  0, 1);
    cyc("s5_c2", 1, 1, 'h55, 0, 0, 0, 'h0,  1, 0);
    cyc("s5_c3", 1, 1, 'h56, 0, 0, 1, 'h55, 1, 0);
    cyc("s5_c4", 1, 0, 'h0,  0, 0, 1, 'h56, 1, 0);
    cyc("s5_c5", 1, 0, 'h0,  0, 0, 0, 'h0,  1, 0);

    // Reset during DRAIN with three words in flight at D=16
    cyc("s6_c0", 1, 0, 'h0,  1, 16, 0, 'h0, 1, 0);
    cyc("s6_c1", 1, 0, 'h0,  0, 0,  0, 'h0, 0, 1);
    cyc("s6_c2", 1, 1, 'h61, 0, 0,  0, 'h0, 1, 0);
    cyc("s6_c3", 1, 1, 'h62, 0, 0,  0, 'h0, 1, 0);
    cyc("s6_c4", 1, 1, 'h63, 0, 0,  0, 'h0, 1, 0);
    cyc("s6_c5", 1, 0, 'h0,  1, 3,  0, 'h0, 1, 0);
    rstn = 1'b0;
    cyc("s6_c6", 1, 0, 'h0,  0, 0,  0, 'h0, 0, 1);
    rstn = 1'b1;
    cyc("s6_c7", 1, 1, 'h71, 0, 0,  0, 'h0,  1, 0);
    cyc("s6_c8", 1, 0, 'h0,  0, 0,  0, 'h0,  1, 0);
    cyc("s6_c9", 1, 0, 'h0,  0, 0,  1, 'h71, 1, 0);
    for (int i = 10; i < 30; i++)
      cyc($sformatf("s6_c%0d", i), 1, 0, 'h0, 0, 0, 0, 'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
